ram_1p_march_tester: RTL

Built-in self-test initiator for the single-port word SRAM (`req`/`we`/`be`/`addr`/`wdata` in, `rvalid`/`rdata` out, one-cycle read latency, read-before-write). On a start pulse it runs a three-pass march over every word:

1. write a pattern;
2. read and check it while overwriting with its inverse;
3. read and check the inverse.

It reports pass/fail, an error count and the first failing address. It sits between the memory and the SoC test/debug logic, muxed onto the RAM port during bring-up.

---
 rtl/ram_1p_march_tester.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_1p_march_tester.sv
// Three-pass march BIST for the single-port word SRAM: write P, read P / write ~P, read ~P.
// Reports pass/fail, a saturating error count and the byte address of the first mismatch.
module ram_1p_march_tester #(
  parameter int unsigned Depth     = 128,
  parameter logic [31:0] BaseAddr  = 32'h0,
  parameter int unsigned ErrCountW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ErrCountW-1:0] err_count_o,
  output logic [31:0]          err_addr_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [3:0]           be_o,
  output logic [31:0]          addr_o,
  output logic [31:0]          wdata_o,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i
);

  localparam int unsigned     IdxW    = $clog2(Depth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);
  localparam logic [31:0]     Golden  = 32'h9E3779B9;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_RDWR, ST_READ, ST_DRAIN, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [31:0]         seed_q, seed_d, pat_d;
  logic                accept, err;
  logic                chk_pend_q;
  logic [31:0]         chk_exp_q, chk_addr_q;
  logic [ErrCountW-1:0] err_cnt_d;
  logic [31:0]         err_addr_d;

  assign be_o = 4'hF;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seed_d     = seed_q;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          seed_d  = seed_i;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = ST_RDWR;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RDWR: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = ST_READ;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_READ: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-cycle values so they line up with state_q.
    pat_d = seed_d ^ (32'(idx_d) * Golden);

    err        = chk_pend_q && (!rvalid_i || (rdata_i != chk_exp_q));
    err_cnt_d  = err_count_o;
    err_addr_d = err_addr_o;
    if (accept) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (err) begin
      if (err_count_o != '1) err_cnt_d = err_count_o + 1'b1;
      if (err_count_o == '0) err_addr_d = chk_addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      seed_q      <= '0;
      req_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= BaseAddr;
      wdata_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      err_count_o <= '0;
      err_addr_o  <= '0;
      chk_pend_q  <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      req_o       <= state_d inside {ST_WRITE, ST_RDWR, ST_READ};
      we_o        <= state_d inside {ST_WRITE, ST_RDWR};
      addr_o      <= BaseAddr + 32'({idx_d, 2'b00});
      wdata_o     <= (state_d == ST_WRITE) ? pat_d :
                     (state_d inside {ST_RDWR, ST_READ}) ? ~pat_d : '0;
      busy_o      <= state_d inside {ST_WRITE, ST_RDWR, ST_READ, ST_DRAIN};
      done_o      <= (state_d == ST_DONE);
      if (accept) pass_o <= 1'b0;
      else if (state_d == ST_DONE) pass_o <= (err_cnt_d == '0);
      err_count_o <= err_cnt_d;
      err_addr_o  <= err_addr_d;
      // wdata_o holds ~P(idx) in both RDWR and READ; RDWR expects the old word P(idx).
      chk_pend_q  <= state_q inside {ST_RDWR, ST_READ};
      chk_exp_q   <= (state_q == ST_RDWR) ? ~wdata_o : wdata_o;
      chk_addr_q  <= addr_o;
    end
  end

endmodule
